// File: rtl/vga_pixel_fifo.sv
// Elastic pixel buffer feeding the ADV7123 DAC driver: frame-aligns the incoming
// stream, pre-fills before streaming, and resynchronises after a mid-frame underflow.
module vga_pixel_fifo #(
  parameter int PIXEL_W = 30,
  parameter int DEPTH   = 1024,
  parameter int PREFILL = 512
) (
  input  logic                     ul1Clock,
  input  logic                     ul1Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIXEL_W-1:0]       in_data,
  input  logic                     in_sof,
  input  logic                     in_eof,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PIXEL_W-1:0]       out_data,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {SYNC, FILL, STREAM, FLUSH} state_t;

  state_t             state, next_state;
  logic [PIXEL_W+1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [PIXEL_W+1:0] head;
  logic               in_frame, eof_seen;
  logic               full, empty, wr_en, rd_en, underflow_cond;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) state <= SYNC;
    else          state <= next_state;
  end

  // A short frame (eof already stored) releases the prefill early.
  always_comb begin
    next_state = state;
    case (state)
      SYNC:    if (in_valid && in_sof) next_state = FILL;
      FILL:    if (level >= LW'(PREFILL) || eof_seen) next_state = STREAM;
      STREAM:  if (underflow_cond) next_state = FLUSH;
      FLUSH:   next_state = SYNC;
      default: next_state = SYNC;
    endcase
  end

  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    wr_en          = 1'b0;
    underflow_cond = 1'b0;
    case (state)
      SYNC: begin
        in_ready = 1'b1;
        wr_en    = in_valid && in_sof;
      end
      FILL: begin
        in_ready = !full;
        wr_en    = in_valid && !full;
      end
      STREAM: begin
        in_ready       = !full;
        wr_en          = in_valid && !full;
        out_valid      = !empty;
        underflow_cond = empty && out_ready && in_frame;
      end
      default: ;
    endcase
    if (ul1Reset) in_ready = 1'b0;
    rd_en     = out_valid && out_ready;
    underflow = underflow_cond && !ul1Reset;
    out_data  = out_valid ? head[PIXEL_W+1:2] : '0;
    out_sof   = out_valid && head[1];
    out_eof   = out_valid && head[0];
  end

  always_ff @(posedge ul1Clock) begin
    if (wr_en) mem[wr_ptr] <= {in_data, in_sof, in_eof};
  end

  // FLUSH empties the buffer in a single cycle so SYNC always starts from zero.
  always_ff @(posedge ul1Clock) begin
    if (ul1Reset || state == FLUSH) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_frame <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
      if (rd_en) begin
        if (head[0])      in_frame <= 1'b0;
        else if (head[1]) in_frame <= 1'b1;
      end
    end
  end

  always_ff @(posedge ul1Clock) begin
    if (ul1Reset)                                eof_seen <= 1'b0;
    else if (state == SYNC)                      eof_seen <= wr_en && in_eof;
    else if (state == FILL && wr_en && in_eof)   eof_seen <= 1'b1;
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed bench for vga_pixel_fifo: a queue-based frame model checked every cycle
// plus hand-computed expectations at the interesting points of each scenario.
module tb_vga_pixel_fifo;

  localparam int PIXEL_W = 30;
  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic               ul1Clock = 1'b0;
  logic               ul1Reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_sof = 1'b0;
  logic               in_eof = 1'b0;
  logic               out_ready = 1'b0;
  logic [PIXEL_W-1:0] in_data = '0;
  logic               in_ready, out_valid, out_sof, out_eof, underflow;
  logic [PIXEL_W-1:0] out_data;
  logic [LW-1:0]      level;

  int checks = 0;
  int errors = 0;

  always #5 ul1Clock = ~ul1Clock;

  vga_pixel_fifo #(.PIXEL_W(PIXEL_W), .DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
    .ul1Clock (ul1Clock),
    .ul1Reset (ul1Reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .in_eof   (in_eof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .level    (level),
    .underflow(underflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  typedef enum {M_SYNC, M_FILL, M_STREAM, M_FLUSH} mode_t;
  mode_t              mMode = M_SYNC;
  logic [PIXEL_W+1:0] mQ[$];
  bit                 mInFrame = 1'b0;
  bit                 mEofSeen = 1'b0;

  // Model of frame behaviour: a queue of {pixel,sof,eof}; compared, then advanced.
  always @(negedge ul1Clock) begin : compare
    logic [PIXEL_W+1:0] hd;
    bit expValid, expReady, expUnder, toStream;
    int size;
    size     = mQ.size();
    hd       = (size > 0) ? mQ[0] : '0;
    expValid = (mMode == M_STREAM) && (size > 0);
    expReady = !ul1Reset && ((mMode == M_SYNC) ||
               (((mMode == M_FILL) || (mMode == M_STREAM)) && (size < DEPTH)));
    expUnder = !ul1Reset && (mMode == M_STREAM) && (size == 0) && out_ready && mInFrame;
    checkOutput("m_level",     32'(level),     32'(size));
    checkOutput("m_in_ready",  32'(in_ready),  32'(expReady));
    checkOutput("m_out_valid", 32'(out_valid), 32'(expValid));
    checkOutput("m_underflow", 32'(underflow), 32'(expUnder));
    checkOutput("m_out_data",  32'(out_data),  expValid ? 32'(hd[PIXEL_W+1:2]) : 32'd0);
    checkOutput("m_out_sof",   32'(out_sof),   32'(expValid && hd[1]));
    checkOutput("m_out_eof",   32'(out_eof),   32'(expValid && hd[0]));
    if (ul1Reset) begin
      mQ.delete();
      mMode    = M_SYNC;
      mInFrame = 1'b0;
      mEofSeen = 1'b0;
    end else begin
      case (mMode)
        M_SYNC: if (in_valid && in_sof) begin
          mQ.push_back({in_data, in_sof, in_eof});
          mEofSeen = in_eof;
          mMode    = M_FILL;
        end
        M_FILL: begin
          toStream = (size >= PREFILL) || mEofSeen;
          if (in_valid && size < DEPTH) begin
            mQ.push_back({in_data, in_sof, in_eof});
            if (in_eof) mEofSeen = 1'b1;
          end
          if (toStream) mMode = M_STREAM;
        end
        M_STREAM: begin
          if (expValid && out_ready) begin
            hd = mQ.pop_front();
            if (hd[0])      mInFrame = 1'b0;
            else if (hd[1]) mInFrame = 1'b1;
          end
          if (in_valid && size < DEPTH) mQ.push_back({in_data, in_sof, in_eof});
          if (expUnder) mMode = M_FLUSH;
        end
        default: begin
          mQ.delete();
          mInFrame = 1'b0;
          mMode    = M_SYNC;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge ul1Clock);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [PIXEL_W-1:0] d, input bit s, input bit e, input bit r);
    in_valid  = v;
    in_data   = d;
    in_sof    = s;
    in_eof    = e;
    out_ready = r;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ul1Reset = 1'b1;
    tick();
    tick();
    checkOutput("rst_in_ready",  32'(in_ready),  0);
    checkOutput("rst_level",     32'(level),     0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data",  32'(out_data),  0);
    ul1Reset = 1'b0;

    // Pixels before the first sof are swallowed.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, PIXEL_W'(32'hA0 + i), 1'b0, 1'b0, 1'b1);
      checkOutput("sync_discard_ready", 32'(in_ready), 1);
      checkOutput("sync_discard_level", 32'(level), 0);
      tick();
    end

    // 20-pixel frame at full rate.
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, PIXEL_W'(k), k == 1, k == 20, 1'b1);
      if (k == 2) begin
        checkOutput("sof_level", 32'(level), 1);
        checkOutput("fill_out_valid", 32'(out_valid), 0);
      end
      if (k == 9) begin
        checkOutput("prefill_level", 32'(level), 8);
        checkOutput("prefill_out_valid", 32'(out_valid), 0);
      end
      if (k == 10) begin
        checkOutput("stream_out_valid", 32'(out_valid), 1);
        checkOutput("stream_first_data", 32'(out_data), 1);
        checkOutput("stream_first_sof", 32'(out_sof), 1);
        checkOutput("stream_level", 32'(level), 9);
      end
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_level", 32'(level), 9);
    checkOutput("drain_head", 32'(out_data), 12);
    repeat (8) tick();
    checkOutput("last_data", 32'(out_data), 20);
    checkOutput("last_eof", 32'(out_eof), 1);
    repeat (4) tick();
    checkOutput("idle_level", 32'(level), 0);
    checkOutput("idle_underflow", 32'(underflow), 0);

    // Fill to full with the consumer stalled.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, PIXEL_W'(32'h100 + k), k == 0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, PIXEL_W'(32'h110), 1'b0, 1'b1, 1'b0);
    checkOutput("full_level", 32'(level), 16);
    checkOutput("full_in_ready", 32'(in_ready), 0);
    checkOutput("full_head", 32'(out_data), 32'h100);
    tick();
    checkOutput("full_hold_level", 32'(level), 16);
    applyStimulus(1'b1, PIXEL_W'(32'h110), 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, PIXEL_W'(32'h110), 1'b0, 1'b1, 1'b0);
    checkOutput("one_read_level", 32'(level), 15);
    checkOutput("one_read_in_ready", 32'(in_ready), 1);
    checkOutput("one_read_head", 32'(out_data), 32'h101);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (18) tick();
    checkOutput("full_drain_level", 32'(level), 0);

    // Upstream stalls mid-frame after pixel 10.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, PIXEL_W'(32'h200 + k), k == 1, 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("stall_level", 32'(level), 1);
    checkOutput("stall_head", 32'(out_data), 32'h20A);
    checkOutput("stall_no_underflow", 32'(underflow), 0);
    tick();
    checkOutput("underflow_pulse", 32'(underflow), 1);
    checkOutput("underflow_out_valid", 32'(out_valid), 0);
    tick();
    checkOutput("flush_underflow", 32'(underflow), 0);
    checkOutput("flush_in_ready", 32'(in_ready), 0);
    tick();
    checkOutput("resync_in_ready", 32'(in_ready), 1);
    for (int k = 11; k <= 20; k++) begin
      applyStimulus(1'b1, PIXEL_W'(32'h200 + k), 1'b0, k == 20, 1'b1);
      tick();
    end
    checkOutput("tail_discard_level", 32'(level), 0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, PIXEL_W'(32'h300 + k), k == 1, k == 10, 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (12) tick();
    checkOutput("next_frame_drain", 32'(level), 0);

    // Reset in the middle of a frame with nine pixels stored.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, PIXEL_W'(32'h500 + k), k == 0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_level", 32'(level), 9);
    ul1Reset = 1'b1;
    #1;
    checkOutput("reset_in_ready_comb", 32'(in_ready), 0);
    tick();
    checkOutput("reset_level", 32'(level), 0);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_underflow", 32'(underflow), 0);
    checkOutput("reset_in_ready", 32'(in_ready), 0);
    checkOutput("reset_out_data", 32'(out_data), 0);
    tick();
    ul1Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, PIXEL_W'(32'h600 + k), 1'b0, 1'b0, 1'b1);
      tick();
    end
    checkOutput("post_reset_discard", 32'(level), 0);

    // Short frame releases the prefill once its eof is stored.
    applyStimulus(1'b1, PIXEL_W'(32'h401), 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, PIXEL_W'(32'h402), 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, PIXEL_W'(32'h403), 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("short_fill_level", 32'(level), 3);
    checkOutput("short_fill_valid", 32'(out_valid), 0);
    tick();
    checkOutput("short_stream_valid", 32'(out_valid), 1);
    checkOutput("short_stream_level", 32'(level), 3);
    checkOutput("short_stream_data", 32'(out_data), 32'h401);
    repeat (6) tick();
    checkOutput("short_empty_level", 32'(level), 0);
    checkOutput("short_no_underflow", 32'(underflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fifo.md
Name: vga_pixel_fifo

Overview:
- Elastic pixel buffer directly upstream of the ADV7123 VGA DAC driver.
- Accepts framed RGB pixels (valid/ready, start-of-frame and end-of-frame markers) from the frame source.
- Aligns the stream to frame boundaries and pre-fills before releasing pixels.
- Presents pixels to the DAC driver on a valid/ready handshake; detects mid-frame underflow and resynchronises on the next frame.

Parameters:
- PIXEL_W, 30, pixel width (10-bit R,G,B packed R[29:20] G[19:10] B[9:0]).
- DEPTH, 1024, FIFO depth in pixels; power of two, >=4.
- PREFILL, 512, occupancy required before streaming starts; 1..DEPTH.

Ports:
- ul1Clock  in  1  pixel clock, all logic rising-edge.
- ul1Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  block accepts pixel this cycle.
- in_data  in  PIXEL_W  upstream pixel.
- in_sof  in  1  first pixel of frame (qualified by in_valid).
- in_eof  in  1  last pixel of frame (qualified by in_valid).
- out_valid  out  1  pixel available to DAC driver.
- out_ready  in  1  DAC driver consumes pixel this cycle.
- out_data  out  PIXEL_W  head pixel.
- out_sof  out  1  head pixel is first of frame.
- out_eof  out  1  head pixel is last of frame.
- level  out  $clog2(DEPTH)+1  current occupancy.
- underflow  out  1  one-cycle pulse on mid-frame underflow.

Behaviour:
- Storage: PIXEL_W+2 bits per entry (data, sof, eof); circular buffer with wrap-around pointers; level in 0..DEPTH.
- Handshake semantics:
  - Write occurs when in_valid && in_ready.
  - Read occurs when out_valid && out_ready.
  - Simultaneous read and write leaves level unchanged.
  - Write-to-out_valid latency is 1 cycle.
  - out_data/out_sof/out_eof are first-word-fall-through: they show the head entry whenever out_valid=1.
  - Outputs hold stable while out_valid && !out_ready.
- in_ready = !full in FILL and STREAM; 1 in SYNC; 0 in FLUSH.
- A full FIFO never accepts a write, even with a same-cycle read.
- Reset (any cycle, including mid-frame): pointers and level = 0, state = SYNC, in_ready = 0 during reset, out_valid = 0, underflow = 0, out_data/out_sof/out_eof = 0.
- State SYNC:
  - Input pixels are accepted and discarded until in_valid && in_sof.
  - That sof pixel is written, then state -> FILL.
- State FILL:
  - Accept writes; out_valid = 0.
  - Move to STREAM when level >= PREFILL, or when an entry with eof has been written (short frame), evaluated on registered level.
- State STREAM:
  - out_valid = (level != 0).
  - Track in_frame: set when a sof pixel is read, cleared when an eof pixel is read.
  - Reading a pixel with both sof and eof leaves in_frame = 0.
- Underflow:
  - Condition: in STREAM, level == 0 && out_ready && in_frame.
  - Action: underflow pulses 1 cycle, state -> FLUSH.
- Empty between frames: in STREAM, level == 0 && !in_frame is not an underflow; remain in STREAM.
- State FLUSH: pointers and level cleared in one cycle, in_frame cleared, state -> SYNC.
- Input sof arriving while in FILL/STREAM is stored normally; no realignment is performed.

Test Plan (DEPTH=16, PREFILL=8):
- Reset, then 4 pixels without sof then sof pixel 0x00000001 -> first 4 discarded (in_ready=1); level=1 after sof; out_valid stays 0.
- Frame of 20 pixels (values 1..20, sof on 1, eof on 20), out_ready=1 continuous, upstream at full rate:
  - out_valid first rises the cycle after level reaches 8.
  - out_data sequence 1..20 in order, out_sof with 1, out_eof with 20, no underflow.
- Fill to 16 with out_ready=0 -> in_ready=0 and level=16; the next pixel is held by upstream. Assert out_ready for one cycle -> level=15, in_ready=1.
- Mid-frame stall: after pixel 10 of a 20-pixel frame upstream stops, consumer keeps out_ready=1:
  - FIFO drains, then underflow pulses exactly once, state passes through FLUSH to SYNC.
  - Remaining pixels 11..20 discarded; the next frame's sof streams cleanly.
- Short 3-pixel frame (sof on first, eof on third) -> streaming starts with level=3 < PREFILL; after eof is read, FIFO empty with out_ready=1 gives no underflow.
- Assert ul1Reset mid-stream with level=9 -> next cycle level=0, out_valid=0, underflow=0, in_ready=0 while reset is high. After release, pixels are discarded until sof.
